// File: rtl/wisc_pipe_pkg.sv
// Shared WISC-SP13 pipeline constants: control-bit layout and per-boundary widths.
package wisc_pipe_pkg;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_JR         = 3;
  localparam int CTRL_DUMP       = 4;

  localparam int CTRL_W_IF_ID  = 1;
  localparam int CTRL_W_ID_EX  = 8;
  localparam int CTRL_W_EX_MEM = 5;
  localparam int CTRL_W_MEM_WB = 3;

  localparam int DATA_W_IF_ID  = 32;
  localparam int DATA_W_ID_EX  = 64;
  localparam int DATA_W_EX_MEM = 48;
  localparam int DATA_W_MEM_WB = 32;

  typedef enum logic [1:0] {
    BND_IF_ID,
    BND_ID_EX,
    BND_EX_MEM,
    BND_MEM_WB
  } stage_bnd_e;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: valid and ctrl are reset/cleared, the payload is not.
module pipe_entry
  import wisc_pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (load && !clear && !rst) begin
      data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage register with valid/ready handshake, flush,
// optional skid entry and a saturating stall counter.
module pipe_stage_reg
  import wisc_pipe_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int CTRL_W  = 8,
  parameter int SKID    = 1,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [STALL_W-1:0] ONE = 1;

  logic              in_fire;
  logic              out_fire;
  logic              main_load;
  logic              main_clear;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;

  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_valid;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;
      logic              promote;
      logic              skid_load;
      logic              skid_clear;

      // ready comes only from the skid flop, never from out_ready
      assign in_ready   = ~skid_valid;
      assign promote    = out_fire & skid_valid;
      assign main_load  = ~flush &
                          (promote | (in_fire & (~out_valid | out_fire)));
      assign main_clear = flush | (out_fire & ~main_load);
      assign skid_load  = in_fire & out_valid & (~out_ready | skid_valid);
      assign skid_clear = flush | (promote & ~skid_load);

      assign main_d_ctrl = promote ? skid_ctrl : in_ctrl;
      assign main_d_data = promote ? skid_data : in_data;

      pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .valid  (skid_valid),
        .ctrl   (skid_ctrl),
        .data   (skid_data)
      );
    end else begin : g_noskid
      assign in_ready    = ~out_valid | out_ready;
      assign main_load   = in_fire;
      assign main_clear  = flush | (out_fire & ~in_fire);
      assign main_d_ctrl = in_ctrl;
      assign main_d_data = in_data;
    end
  endgenerate

  pipe_entry #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .clear  (main_clear),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .valid  (out_valid),
    .ctrl   (out_ctrl),
    .data   (out_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a skid and a non-skid instance with the same stimulus and checks
// both against queue-based reference models.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_ctrl;
  logic [15:0] in_data;
  logic        flush;
  logic        out_ready;

  logic        a_ir, a_ov, b_ir, b_ov;
  logic [7:0]  a_oc, b_oc;
  logic [15:0] a_od, b_od;
  logic [3:0]  a_sc;
  logic [15:0] b_sc;

  typedef struct packed {
    logic [7:0]  c;
    logic [15:0] d;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  int   sa, sb;
  int   errors = 0;
  int   checks = 0;
  bit   seen_c = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W (16), .CTRL_W (8), .SKID (1), .STALL_W (4)
  ) dut_a (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (a_ir),
    .in_ctrl (in_ctrl), .in_data (in_data),
    .flush (flush),
    .out_valid (a_ov), .out_ready (out_ready),
    .out_ctrl (a_oc), .out_data (a_od),
    .stall_cnt (a_sc)
  );

  pipe_stage_reg #(
    .DATA_W (16), .CTRL_W (8), .SKID (0), .STALL_W (16)
  ) dut_b (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (b_ir),
    .in_ctrl (in_ctrl), .in_data (in_data),
    .flush (flush),
    .out_valid (b_ov), .out_ready (out_ready),
    .out_ctrl (b_oc), .out_data (b_od),
    .stall_cnt (b_sc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    chk("a_out_valid", 32'(a_ov), 32'(qa.size() > 0));
    if (qa.size() > 0) begin
      chk("a_out_ctrl", 32'(a_oc), 32'(qa[0].c));
      chk("a_out_data", 32'(a_od), 32'(qa[0].d));
    end else begin
      chk("a_out_ctrl_bubble", 32'(a_oc), 32'd0);
    end
    chk("a_in_ready", 32'(a_ir), 32'(qa.size() < 2));
    chk("a_stall_cnt", 32'(a_sc), 32'(sa));
    chk("b_out_valid", 32'(b_ov), 32'(qb.size() > 0));
    if (qb.size() > 0) begin
      chk("b_out_ctrl", 32'(b_oc), 32'(qb[0].c));
      chk("b_out_data", 32'(b_od), 32'(qb[0].d));
    end else begin
      chk("b_out_ctrl_bubble", 32'(b_oc), 32'd0);
    end
    chk("b_in_ready", 32'(b_ir), 32'(qb.size() == 0 || out_ready));
    chk("b_stall_cnt", 32'(b_sc), 32'(sb));
    if ((a_ov && a_od == 16'hCCCC) || (b_ov && b_od == 16'hCCCC))
      seen_c = 1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] c,
                       input logic [15:0] d, input logic fl,
                       input logic ordy);
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
    #1 compare();
  endtask

  task automatic advance();
    bit ifa, ofa, ifb, ofb;
    @(posedge clk);
    if (rst) begin
      qa.delete();
      qb.delete();
      sa = 0;
      sb = 0;
    end else begin
      ifa = in_valid && qa.size() < 2 && !flush;
      ofa = qa.size() > 0 && out_ready;
      ifb = in_valid && (qb.size() == 0 || out_ready) && !flush;
      ofb = qb.size() > 0 && out_ready;
      if (qa.size() > 0 && !out_ready && sa < 15) sa++;
      if (qb.size() > 0 && !out_ready && sb < 65535) sb++;
      if (flush) begin
        qa.delete();
      end else begin
        if (ofa) void'(qa.pop_front());
        if (ifa) qa.push_back('{in_ctrl, in_data});
      end
      if (flush) begin
        qb.delete();
      end else begin
        if (ofb) void'(qb.pop_front());
        if (ifb) qb.push_back('{in_ctrl, in_data});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    sa = 0;
    sb = 0;
    @(negedge clk);
    drive(0, 8'h00, 16'h0000, 0, 0);
    advance();
    rst = 1'b0;

    // in-order streaming, one per cycle
    for (int i = 1; i <= 8; i++) begin
      drive(1, 8'(i), 16'(i), 0, 1);
      advance();
    end
    drive(0, 8'h00, 16'h0000, 0, 1);
    advance();

    // skid fill and drain
    drive(1, 8'h11, 16'hAAAA, 0, 0);
    advance();
    drive(1, 8'h22, 16'hBBBB, 0, 0);
    advance();
    drive(0, 8'h00, 16'h0000, 0, 0);
    chk("t3_ready_low", 32'(a_ir), 32'd0);
    advance();
    drive(0, 8'h00, 16'h0000, 0, 1);
    chk("t3_first", 32'(a_od), 32'hAAAA);
    advance();
    drive(0, 8'h00, 16'h0000, 0, 1);
    chk("t3_second", 32'(a_od), 32'hBBBB);
    chk("t3_ready_back", 32'(a_ir), 32'd1);
    advance();

    // flush drops held entries and the flush-cycle input
    drive(1, 8'h33, 16'h1234, 0, 0);
    advance();
    drive(1, 8'h44, 16'h5678, 0, 0);
    advance();
    drive(1, 8'hFF, 16'hCCCC, 1, 0);
    advance();
    drive(0, 8'h00, 16'h0000, 0, 1);
    chk("t4_a_valid", 32'(a_ov), 32'd0);
    chk("t4_a_ctrl", 32'(a_oc), 32'd0);
    chk("t4_b_ctrl", 32'(b_oc), 32'd0);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h00, 16'h0000, 0, 1);
      advance();
    end

    // combinational ready without skid
    drive(1, 8'h01, 16'h1111, 0, 1);
    advance();
    drive(0, 8'h00, 16'h0000, 0, 0);
    chk("t5_ready_low", 32'(b_ir), 32'd0);
    out_ready = 1'b1;
    #1 chk("t5_ready_high", 32'(b_ir), 32'd1);
    advance();

    // async reset with both entries full
    drive(1, 8'h55, 16'h0101, 0, 0);
    advance();
    drive(1, 8'h66, 16'h0202, 0, 0);
    advance();
    drive(0, 8'h00, 16'h0000, 0, 0);
    chk("t1_pre_full", 32'(a_ir), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("t1_valid", 32'(a_ov), 32'd0);
    chk("t1_ctrl", 32'(a_oc), 32'd0);
    chk("t1_ready", 32'(a_ir), 32'd1);
    chk("t1_stall", 32'(a_sc), 32'd0);
    chk("t1_b_valid", 32'(b_ov), 32'd0);
    advance();
    rst = 1'b0;

    // stall counter saturation
    drive(1, 8'h77, 16'h0707, 0, 0);
    advance();
    for (int i = 0; i < 20; i++) begin
      drive(0, 8'h00, 16'h0000, 0, 0);
      advance();
    end
    drive(0, 8'h00, 16'h0000, 0, 0);
    chk("t6_sat", 32'(a_sc), 32'd15);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h00, 16'h0000, 0, 1);
      advance();
    end

    // random traffic against the models
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)),
            16'($urandom_range(0, 16'hBFFF)),
            1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 3) != 0));
      advance();
    end

    chk("t4_no_cccc", 32'(seen_c), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
